alu_resp_pipe: RTL
==================

// Module: alu_resp_pipe
// PURPOSE
//  Pipelined 8-bit ALU responder: accepts (A, B, ALU_Sel, tag) ops from a requester over valid/ready
//  and returns (ALU_Out, CarryOut, err, tag) over valid/ready. Two register stages, full throughput,
//  stall-correct under backpressure. Serves as the synthesizable far end for ALU stimulus generators.
// PARAMETERS
//  WIDTH   8   operand/result width
//  TAG_W   4   requester tag width, returned unchanged with each result
// PORTS
//  clk        in   1        clock; all logic on rising edge
//  reset      in   1        synchronous, active-high
//  in_valid   in   1        request valid
//  in_ready   out  1        responder can accept request this cycle
//  A          in   WIDTH    operand A
//  B          in   WIDTH    operand B
//  ALU_Sel    in   4        opcode
//  in_tag     in   TAG_W    request tag
//  out_valid  out  1        result valid
//  out_ready  in   1        requester accepts result this cycle
//  ALU_Out    out  WIDTH    result
//  CarryOut   out  1        carry/borrow/overflow flag
//  err        out  1        divide-by-zero flag
//  out_tag    out  TAG_W    tag of this result
// BEHAVIOUR
//  - Reset: s1_valid=0, out_valid=0, ALU_Out=0, CarryOut=0, err=0, out_tag=0; in_ready=1 on first
//    cycle after reset deasserts. Reset mid-operation discards all in-flight ops; no result emitted.
//  - Stage 1 registers A,B,ALU_Sel,tag on accept (in_valid & in_ready). Stage 2 computes from S1 and
//    registers result. Latency: accept in cycle N -> out_valid in cycle N+2 with no backpressure.
//  - Stall: s2_free = !out_valid | out_ready; s1 advances when s1_valid & s2_free;
//    in_ready = !s1_valid | s2_free (combinational). Throughput 1 op/cycle with out_ready held high.
//  - out_valid held with ALU_Out/CarryOut/err/out_tag stable until out_ready; no drop, no duplication,
//    results in request order. Simultaneous accept-in and accept-out in same cycle is legal.
//  - Opcodes (sum/diff computed WIDTH+1 bits; unlisted flags = 0):
//    0 add A+B, Carry=bit WIDTH | 1 sub A-B, Carry=borrow (A<B) | 2 mul low WIDTH bits,
//    Carry=|high WIDTH bits | 3 div A/B; B=0 -> Out=all-ones, err=1 | 4 A<<1, Carry=A[msb] |
//    5 A>>1, Carry=A[0] | 6 rotl1 A | 7 rotr1 A | 8 A&B | 9 A|B | 10 A^B | 11 ~(A|B) |
//    12 ~(A&B) | 13 ~(A^B) | 14 (A>B)?1:0 | 15 (A==B)?1:0.
//  - Compare results zero-extended to WIDTH. All arithmetic unsigned, wraps modulo 2^WIDTH.
//  - in_* ignored when in_valid=0; out_ready ignored when out_valid=0.
// TESTING
//  1 A=0x0A,B=0x02, Sel 0..15 back-to-back, out_ready=1 -> 0C,08,14,05,14,05,14,05,02,0A,08,F5,FD,F7,
//    01,00; all Carry=0, err=0; one result/cycle, first at cycle 2 after first accept.
//  2 A=0xF6,B=0x0A: Sel0 -> Out=0x00,Carry=1; Sel1 -> Out=0xEC,Carry=0; Sel2 -> Out=0x9C,Carry=1.
//  3 A=0x0A,B=0x00,Sel=3,tag=5 -> Out=0xFF, err=1, out_tag=5; next op Sel=0 -> err=0.
//  4 Backpressure: 4 ops tags 1..4 issued, out_ready=0 for 5 cycles -> in_ready falls after 2 accepted,
//    outputs stable; release -> tags 1,2,3,4 in order, none lost or repeated.
//  5 Random out_ready (50%), 1000 random ops vs reference model -> all match, order preserved.
//  6 reset asserted with 2 ops in flight -> out_valid=0 next cycle; after release, no stale results.

Source files
------------

// File: rtl/alu_resp_pipe.sv
// Two-stage pipelined ALU responder over valid/ready: operands registered in s1, result in s2.
// Accept in cycle N gives out_valid in N+2; a held output stalls s1, which then drops in_ready.
module alu_resp_pipe #(
   parameter int WIDTH = 8,
   parameter int TAG_W = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic [3:0]       ALU_Sel,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] ALU_Out,
   output logic             CarryOut,
   output logic             err,
   output logic [TAG_W-1:0] out_tag
);

   logic             s1_valid;
   logic [WIDTH-1:0] s1_a;
   logic [WIDTH-1:0] s1_b;
   logic [3:0]       s1_sel;
   logic [TAG_W-1:0] s1_tag;

   logic s2_free;
   logic s1_adv;
   logic accept;

   assign s2_free  = !out_valid || out_ready;
   assign s1_adv   = s1_valid && s2_free;
   assign in_ready = !s1_valid || s2_free;
   assign accept   = in_valid && in_ready;

   logic [WIDTH:0]       sum;
   logic [WIDTH:0]       diff;
   logic [2*WIDTH-1:0]   prod;
   logic [WIDTH-1:0]     res;
   logic                 res_carry;
   logic                 res_err;

   always_comb begin
      sum       = {1'b0, s1_a} + {1'b0, s1_b};
      diff      = {1'b0, s1_a} - {1'b0, s1_b};
      prod      = {{WIDTH{1'b0}}, s1_a} * {{WIDTH{1'b0}}, s1_b};
      res       = '0;
      res_carry = 1'b0;
      res_err   = 1'b0;
      case (s1_sel)
         4'd0:  begin res = sum[WIDTH-1:0];  res_carry = sum[WIDTH];  end
         // The extra bit of the widened difference is exactly the borrow (A < B).
         4'd1:  begin res = diff[WIDTH-1:0]; res_carry = diff[WIDTH]; end
         4'd2:  begin res = prod[WIDTH-1:0]; res_carry = |prod[2*WIDTH-1:WIDTH]; end
         4'd3: begin
            if (s1_b == '0) begin
               res     = '1;
               res_err = 1'b1;
            end else begin
               res = s1_a / s1_b;
            end
         end
         4'd4:  begin res = {s1_a[WIDTH-2:0], 1'b0}; res_carry = s1_a[WIDTH-1]; end
         4'd5:  begin res = {1'b0, s1_a[WIDTH-1:1]}; res_carry = s1_a[0];       end
         4'd6:  res = {s1_a[WIDTH-2:0], s1_a[WIDTH-1]};
         4'd7:  res = {s1_a[0], s1_a[WIDTH-1:1]};
         4'd8:  res = s1_a & s1_b;
         4'd9:  res = s1_a | s1_b;
         4'd10: res = s1_a ^ s1_b;
         4'd11: res = ~(s1_a | s1_b);
         4'd12: res = ~(s1_a & s1_b);
         4'd13: res = ~(s1_a ^ s1_b);
         4'd14: res = {{(WIDTH-1){1'b0}}, (s1_a > s1_b)};
         4'd15: res = {{(WIDTH-1){1'b0}}, (s1_a == s1_b)};
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         s1_valid  <= 1'b0;
         s1_a      <= '0;
         s1_b      <= '0;
         s1_sel    <= '0;
         s1_tag    <= '0;
         out_valid <= 1'b0;
         ALU_Out   <= '0;
         CarryOut  <= 1'b0;
         err       <= 1'b0;
         out_tag   <= '0;
      end else begin
         if (accept) begin
            s1_valid <= 1'b1;
            s1_a     <= A;
            s1_b     <= B;
            s1_sel   <= ALU_Sel;
            s1_tag   <= in_tag;
         end else if (s1_adv) begin
            s1_valid <= 1'b0;
         end

         // Output registers only load on advance, so a stalled result stays stable.
         if (s1_adv) begin
            out_valid <= 1'b1;
            ALU_Out   <= res;
            CarryOut  <= res_carry;
            err       <= res_err;
            out_tag   <= s1_tag;
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule
